// File: rtl/chirp_sequence_ctrl_pkg.sv
// Shared constants for the chirp burst sequencer: state encodings and parameter defaults.
package chirp_sequence_ctrl_pkg;

  localparam int unsigned DefaultCntWidth    = 32;
  localparam int unsigned DefaultInitTimeout = 1024;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StInit  = 3'd1;
  localparam state_t StLead  = 3'd2;
  localparam state_t StChirp = 3'd3;
  localparam state_t StTail  = 3'd4;
  localparam state_t StGap   = 3'd5;

endpackage

// File: rtl/chirp_sequence_ctrl_cycle_counter.sv
// Load / decrement / zero-flag down-counter, shared by the lead, tail and init-timeout phases.
module chirp_sequence_ctrl_cycle_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  // Load has priority; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - One;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/chirp_sequence_ctrl.sv
// Burst sequencer: issues chirp_init/chirp_enable to the DDS and frames adc_enable around
// each chirp, spacing chirps by a PRI measured from one chirp_init to the next.
module chirp_sequence_ctrl
  import chirp_sequence_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = DefaultCntWidth,
  parameter int unsigned INIT_TIMEOUT = DefaultInitTimeout
) (
  input  logic                 clk_245,
  input  logic                 clk_245_rst,
  input  logic                 seq_start,
  input  logic                 seq_stop,
  input  logic [CNT_WIDTH-1:0] num_chirps,
  input  logic [CNT_WIDTH-1:0] pri_cycles,
  input  logic [CNT_WIDTH-1:0] adc_lead,
  input  logic [CNT_WIDTH-1:0] adc_tail,
  input  logic                 fifo_almost_full,
  input  logic                 chirp_ready,
  input  logic                 chirp_done,
  output logic                 chirp_init,
  output logic                 chirp_enable,
  output logic                 adc_enable,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_aborted,
  output logic                 pri_overrun,
  output logic                 init_timeout,
  output logic [CNT_WIDTH-1:0] chirp_idx
);

  localparam logic [CNT_WIDTH-1:0] One         = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TimeoutLoad = CNT_WIDTH'(INIT_TIMEOUT - 1);

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] num_q, num_d, pri_q, pri_d, lead_q, lead_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d, pri_cnt_q, pri_cnt_d, pri_inc;
  logic                 abort_pend_q, abort_pend_d;
  logic                 aborted_q, aborted_d, overrun_q, overrun_d, timeout_q, timeout_d;
  logic                 done_d, enter_gap;
  logic                 chirp_init_q, chirp_enable_q, adc_enable_q, busy_q, done_q;

  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [CNT_WIDTH-1:0] cnt_load_val;

  chirp_sequence_ctrl_cycle_counter #(
    .Width (CNT_WIDTH)
  ) u_cycle_counter (
    .clk_i      (clk_245),
    .rst_i      (clk_245_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Saturating PRI increment; the value pri_cnt will hold next cycle while busy.
  assign pri_inc = (&pri_cnt_q) ? pri_cnt_q : pri_cnt_q + One;

  // Sequencer FSM: next state, latched config, sticky flags and phase counter control.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    pri_d        = pri_q;
    lead_d       = lead_q;
    tail_d       = tail_q;
    idx_d        = idx_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;
    done_d       = 1'b0;
    enter_gap    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      StIdle: begin
        if (seq_start && !seq_stop) begin
          num_d        = num_chirps;
          pri_d        = pri_cycles;
          lead_d       = adc_lead;
          tail_d       = adc_tail;
          idx_d        = '0;
          abort_pend_d = 1'b0;
          aborted_d    = 1'b0;
          overrun_d    = 1'b0;
          timeout_d    = 1'b0;
          if (num_chirps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = StInit;
            cnt_load     = 1'b1;
            cnt_load_val = TimeoutLoad;
          end
        end
      end
      StInit: begin
        if (seq_stop) begin
          aborted_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else if (chirp_ready) begin
          if (lead_q == '0) begin
            state_d = StChirp;
          end else begin
            state_d      = StLead;
            cnt_load     = 1'b1;
            cnt_load_val = lead_q - One;
          end
        end else if (cnt_zero) begin
          timeout_d = 1'b1;
          aborted_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StLead: begin
        if (seq_stop) abort_pend_d = 1'b1;
        if (cnt_zero) begin
          state_d = StChirp;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StChirp: begin
        if (seq_stop) abort_pend_d = 1'b1;
        if (chirp_done) begin
          if (tail_q == '0) begin
            enter_gap = 1'b1;
          end else begin
            state_d      = StTail;
            cnt_load     = 1'b1;
            cnt_load_val = tail_q - One;
          end
        end
      end
      StTail: begin
        if (seq_stop) abort_pend_d = 1'b1;
        if (cnt_zero) begin
          enter_gap = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StGap: begin
        if (seq_stop || abort_pend_q) begin
          aborted_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else if (idx_q == num_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if ((pri_cnt_q >= pri_q) && !fifo_almost_full) begin
          state_d      = StInit;
          cnt_load     = 1'b1;
          cnt_load_val = TimeoutLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame closed: count the chirp and judge the PRI against the first GAP cycle's count.
    if (enter_gap) begin
      state_d = StGap;
      idx_d   = idx_q + One;
      if (pri_inc > pri_q) overrun_d = 1'b1;
    end
  end

  // PRI counter restarts at 1 on every chirp_init cycle and free-runs while busy.
  always_comb begin
    pri_cnt_d = pri_cnt_q;
    if ((state_d == StInit) && (state_q != StInit)) begin
      pri_cnt_d = One;
    end else if (state_q != StIdle) begin
      pri_cnt_d = pri_inc;
    end
  end

  // State, config and status registers.
  always_ff @(posedge clk_245 or posedge clk_245_rst) begin
    if (clk_245_rst) begin
      state_q      <= StIdle;
      num_q        <= '0;
      pri_q        <= '0;
      lead_q       <= '0;
      tail_q       <= '0;
      idx_q        <= '0;
      pri_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      pri_q        <= pri_d;
      lead_q       <= lead_d;
      tail_q       <= tail_d;
      idx_q        <= idx_d;
      pri_cnt_q    <= pri_cnt_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  // Output decode from the next state so registered outputs line up with the state register.
  always_ff @(posedge clk_245 or posedge clk_245_rst) begin
    if (clk_245_rst) begin
      chirp_init_q   <= 1'b0;
      chirp_enable_q <= 1'b0;
      adc_enable_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      chirp_init_q   <= (state_d == StInit) && (state_q != StInit);
      chirp_enable_q <= (state_d == StChirp);
      adc_enable_q   <= (state_d == StLead) || (state_d == StChirp) || (state_d == StTail);
      busy_q         <= (state_d != StIdle);
      done_q         <= done_d;
    end
  end

  assign chirp_init   = chirp_init_q;
  assign chirp_enable = chirp_enable_q;
  assign adc_enable   = adc_enable_q;
  assign seq_busy     = busy_q;
  assign seq_done     = done_q;
  assign seq_aborted  = aborted_q;
  assign pri_overrun  = overrun_q;
  assign init_timeout = timeout_q;
  assign chirp_idx    = idx_q;

endmodule
